// File: rtl/bit_framer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bit_framer_pkg : shared types/constants for the sync-word framer      |
// | Rev 1.0 -- BF_BYTE_BITS widens to 9 when BIT_FRAMER_PARITY_EN is set  |
// +----------------------------------------------------------------------+
package bit_framer_pkg;

  typedef enum logic [0:0] {
    HUNT    = 1'b0,
    PAYLOAD = 1'b1
  } bf_state_t;

  localparam logic [7:0] BF_SYNC_DEFAULT = 8'hA5;

`ifdef BIT_FRAMER_PARITY_EN
  localparam int BF_BYTE_BITS = 9;
`else
  localparam int BF_BYTE_BITS = 8;
`endif

  // Odd parity: the data ones plus the parity bit must total an odd count.
  function automatic logic bf_odd_parity_ok(input logic [7:0] data, input logic par);
    return (^data) ^ par;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bit_framer_phase.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bit_framer_phase : tracks the 2:1 sampler phase, strobes new bits     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module bit_framer_phase (
  input  logic clk,
  input  logic rst,
  output logic cap
);

  logic r_ph;

  // Mirrors the sampler's own state bit, so both leave reset in lockstep.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_ph <= 1'b0;
    else      r_ph <= ~r_ph;
  end

  assign cap = ~r_ph;

endmodule
`default_nettype wire

// File: rtl/bit_framer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bit_framer : hunts SYNC_WORD, then emits PAYLOAD_LEN MSB-first bytes  |
// | Rev 1.0 -- optional odd parity per byte via BIT_FRAMER_PARITY_EN      |
// +----------------------------------------------------------------------+
module bit_framer
  import bit_framer_pkg::*;
#(
  parameter logic [7:0] SYNC_WORD   = BF_SYNC_DEFAULT,
  parameter int         PAYLOAD_LEN = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bit_in,
  output logic [7:0] dout,
  output logic       dout_valid,
  output logic       frame_start,
  output logic       frame_end,
  output logic       locked,
  output logic [7:0] frame_cnt,
  output logic       parity_err
);

  localparam int         c_SHW       = BF_BYTE_BITS - 1;
  localparam logic [3:0] c_LAST_BIT  = 4'(BF_BYTE_BITS - 1);
  localparam logic [3:0] c_LAST_BYTE = 4'(PAYLOAD_LEN - 1);

  logic             w_cap;
  bf_state_t        r_state;
  logic [6:0]       r_sr;
  logic [c_SHW-1:0] r_byte;
  logic [3:0]       r_bit_cnt;
  logic [3:0]       r_byte_cnt;
  logic [7:0]       r_dout;
  logic             r_dout_valid;
  logic             r_frame_start;
  logic             r_frame_end;
  logic             r_locked;
  logic [7:0]       r_frame_cnt;

  logic [7:0]       w_data;
  logic             w_par_ok;
  logic             w_sync_hit;
  logic             w_last_bit;
  logic             w_last_byte;

  bit_framer_phase u_phase (
    .clk (clk),
    .rst (rst),
    .cap (w_cap)
  );

  // With parity the final captured bit is the parity bit, so the data byte
  // is already complete in the shift register.
`ifdef BIT_FRAMER_PARITY_EN
  assign w_data   = r_byte;
  assign w_par_ok = bf_odd_parity_ok(r_byte, bit_in);
`else
  assign w_data   = {r_byte, bit_in};
  assign w_par_ok = 1'b1;
`endif

  assign w_sync_hit  = ({r_sr, bit_in} == SYNC_WORD);
  assign w_last_bit  = (r_bit_cnt == c_LAST_BIT);
  assign w_last_byte = (r_byte_cnt == c_LAST_BYTE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= HUNT;
      r_sr          <= '0;
      r_byte        <= '0;
      r_bit_cnt     <= '0;
      r_byte_cnt    <= '0;
      r_dout        <= '0;
      r_dout_valid  <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_end   <= 1'b0;
      r_locked      <= 1'b0;
      r_frame_cnt   <= '0;
    end else begin
      r_dout_valid  <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_end   <= 1'b0;
      if (w_cap) begin
        case (r_state)
          HUNT: begin
            if (w_sync_hit) begin
              r_state       <= PAYLOAD;
              r_frame_start <= 1'b1;
              r_locked      <= 1'b1;
              r_bit_cnt     <= '0;
              r_byte_cnt    <= '0;
              r_sr          <= '0;
            end else begin
              r_sr <= {r_sr[5:0], bit_in};
            end
          end
          PAYLOAD: begin
            if (!w_last_bit) begin
              r_byte    <= {r_byte[c_SHW-2:0], bit_in};
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end else begin
              r_bit_cnt <= '0;
              if (!w_par_ok) begin
                // Bad parity abandons the frame without emitting the byte.
                r_state  <= HUNT;
                r_locked <= 1'b0;
                r_sr     <= '0;
              end else begin
                r_dout       <= w_data;
                r_dout_valid <= 1'b1;
                if (w_last_byte) begin
                  r_frame_end <= 1'b1;
                  r_frame_cnt <= r_frame_cnt + 8'd1;
                  r_state     <= HUNT;
                  r_locked    <= 1'b0;
                  r_sr        <= '0;
                end else begin
                  r_byte_cnt <= r_byte_cnt + 4'd1;
                end
              end
            end
          end
          default: r_state <= HUNT;
        endcase
      end
    end
  end

`ifdef BIT_FRAMER_PARITY_EN
  logic r_parity_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_parity_err <= 1'b0;
    else      r_parity_err <= w_cap && (r_state == PAYLOAD) && w_last_bit && !w_par_ok;
  end

  assign parity_err = r_parity_err;
`else
  assign parity_err = 1'b0;
`endif

  assign dout        = r_dout;
  assign dout_valid  = r_dout_valid;
  assign frame_start = r_frame_start;
  assign frame_end   = r_frame_end;
  assign locked      = r_locked;
  assign frame_cnt   = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_bit_framer.sv
`default_nettype none
`timescale 1ns/1ps
// Self-checking bench for bit_framer: bit-stream scan model plus literal pins.
module tb_bit_framer;

  localparam int         LEN  = 4;
  localparam logic [7:0] SYNC = 8'hA5;
  localparam int         MAXB = 12000;
`ifdef BIT_FRAMER_PARITY_EN
  localparam int NB  = 9;
  localparam bit PAR = 1'b1;
`else
  localparam int NB  = 8;
  localparam bit PAR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       bit_in = 1'b0;
  logic [7:0] dout;
  logic       dout_valid;
  logic       frame_start;
  logic       frame_end;
  logic       locked;
  logic [7:0] frame_cnt;
  logic       parity_err;

  always #5 clk = ~clk;

  bit_framer #(.SYNC_WORD(SYNC), .PAYLOAD_LEN(LEN)) dut (
    .clk         (clk),
    .rst         (rst),
    .bit_in      (bit_in),
    .dout        (dout),
    .dout_valid  (dout_valid),
    .frame_start (frame_start),
    .frame_end   (frame_end),
    .locked      (locked),
    .frame_cnt   (frame_cnt),
    .parity_err  (parity_err)
  );

  // Stimulus bit stream (one entry per sampler bit) and per-capture expectations.
  bit         bits    [MAXB];
  int         nb;
  bit         e_fs    [MAXB];
  bit         e_fe    [MAXB];
  bit         e_dv    [MAXB];
  bit         e_pe    [MAXB];
  bit         e_lock  [MAXB];
  logic [7:0] e_dout  [MAXB];
  logic [7:0] e_fcnt  [MAXB];
  bit         ev_lset [MAXB];
  bit         ev_lclr [MAXB];
  logic [7:0] ev_d    [MAXB];

  int         checks = 0;
  int         failures = 0;
  int         ecnt = 0;
  bit         chk_en = 1'b0;
  int         n_dv, n_fs, n_fe, n_pe;
  logic [7:0] got[$];
  int         ck, cci;
  bit         cev;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", nm, $time, act, exp);
    end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_dout"}, dout, 0);
    chk({nm, "_dout_valid"}, dout_valid, 0);
    chk({nm, "_frame_start"}, frame_start, 0);
    chk({nm, "_frame_end"}, frame_end, 0);
    chk({nm, "_locked"}, locked, 0);
    chk({nm, "_frame_cnt"}, frame_cnt, 0);
    chk({nm, "_parity_err"}, parity_err, 0);
  endtask

  task automatic push_bit(input bit b);
    bits[nb] = b;
    nb++;
  endtask

  task automatic push_raw(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) push_bit(v[i]);
  endtask

  task automatic push_byte(input logic [7:0] v, input bit bad);
    push_raw(v);
    if (PAR) push_bit((~^v) ^ bad);
  endtask

  task automatic push_frame(input logic [7:0] b0, b1, b2, b3);
    push_raw(SYNC);
    push_byte(b0, 1'b0);
    push_byte(b1, 1'b0);
    push_byte(b2, 1'b0);
    push_byte(b3, 1'b0);
  endtask

  // Scans the whole bit stream: sync search over bits since the last hunt
  // entry (older bits count as zero), then LEN bytes of NB bits each.
  task automatic build_model();
    int pos, h, p, endi;
    logic [7:0] w, d, dcur, fc;
    bit lk, abort;
    for (int i = 0; i < nb; i++) begin
      e_fs[i] = 0; e_fe[i] = 0; e_dv[i] = 0; e_pe[i] = 0;
      ev_lset[i] = 0; ev_lclr[i] = 0; ev_d[i] = 8'h00;
    end
    pos = 0;
    h = 0;
    while (pos < nb) begin
      w = 8'h00;
      for (int j = ((pos - 7) > h) ? pos - 7 : h; j <= pos; j++) w = {w[6:0], bits[j]};
      if (w == SYNC) begin
        e_fs[pos] = 1; ev_lset[pos] = 1;
        p = pos + 1;
        abort = 0;
        for (int b = 0; b < LEN && !abort; b++) begin
          if (p + NB - 1 >= nb) begin
            abort = 1;
            p = nb;
          end else begin
            d = 8'h00;
            for (int q = 0; q < 8; q++) d = {d[6:0], bits[p + q]};
            endi = p + NB - 1;
            if (PAR && ((^d) == bits[p + 8])) begin
              e_pe[endi] = 1; ev_lclr[endi] = 1; abort = 1;
            end else begin
              e_dv[endi] = 1; ev_d[endi] = d;
              if (b == LEN - 1) begin
                e_fe[endi] = 1; ev_lclr[endi] = 1;
              end
            end
            p = endi + 1;
          end
        end
        pos = p;
        h = p;
      end else begin
        pos++;
      end
    end
    lk = 0; dcur = 8'h00; fc = 8'h00;
    for (int i = 0; i < nb; i++) begin
      if (ev_lset[i]) lk = 1;
      if (ev_lclr[i]) lk = 0;
      if (e_dv[i]) dcur = ev_d[i];
      if (e_fe[i]) fc = fc + 8'd1;
      e_lock[i] = lk; e_dout[i] = dcur; e_fcnt[i] = fc;
    end
  endtask

  // Edge k after reset release: even edges capture bit k/2 and carry its pulses.
  always @(posedge clk) begin
    if (chk_en) begin
      ck = ecnt;
      ecnt++;
      #1;
      cci = ck / 2;
      cev = (ck % 2) == 0;
      chk("dout_valid", dout_valid, cev & e_dv[cci]);
      chk("frame_start", frame_start, cev & e_fs[cci]);
      chk("frame_end", frame_end, cev & e_fe[cci]);
      chk("parity_err", parity_err, cev & e_pe[cci]);
      chk("locked", locked, e_lock[cci]);
      chk("dout", dout, e_dout[cci]);
      chk("frame_cnt", frame_cnt, e_fcnt[cci]);
      if (dout_valid) got.push_back(dout);
      n_dv += dout_valid;
      n_fs += frame_start;
      n_fe += frame_end;
      n_pe += parity_err;
    end
  end

  task automatic do_reset();
    chk_en = 0;
    @(negedge clk);
    rst = 0;
    bit_in = 0;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst = 1;
    ecnt = 0;
    n_dv = 0; n_fs = 0; n_fe = 0; n_pe = 0;
    got.delete();
    chk_en = 1;
  endtask

  task automatic run_bits(input int cnt);
    for (int i = 0; i < cnt; i++) begin
      bit_in = bits[i];
      @(negedge clk);
      @(negedge clk);
    end
    chk_en = 0;
  endtask

  task automatic run_all();
    build_model();
    do_reset();
    run_bits(nb);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] r0, r1, r2, r3;

    // Basic frame
    nb = 0;
    push_frame(8'h12, 8'h34, 8'h56, 8'h78);
    run_all();
    chk("t1_ndv", n_dv, 4);
    chk("t1_b0", got[0], 8'h12);
    chk("t1_b1", got[1], 8'h34);
    chk("t1_b2", got[2], 8'h56);
    chk("t1_b3", got[3], 8'h78);
    chk("t1_nfs", n_fs, 1);
    chk("t1_nfe", n_fe, 1);
    chk("t1_fcnt", frame_cnt, 1);

    // Leading noise, then a frame whose payload is all sync bytes
    nb = 0;
    push_raw(8'hFF);
    push_raw(8'h00);
    push_frame(8'h12, 8'h34, 8'h56, 8'h78);
    push_frame(8'hA5, 8'hA5, 8'hA5, 8'hA5);
    run_all();
    chk("t2_nfs", n_fs, 2);
    chk("t2_nfe", n_fe, 2);
    chk("t2_ndv", n_dv, 8);
    chk("t2_b0", got[0], 8'h12);
    chk("t2_b3", got[3], 8'h78);
    chk("t2_b4", got[4], 8'hA5);
    chk("t2_b7", got[7], 8'hA5);
    chk("t2_fcnt", frame_cnt, 2);

    // Back-to-back frames, no gap
    nb = 0;
    push_frame(8'h01, 8'h02, 8'h03, 8'h04);
    push_frame(8'hF1, 8'hF2, 8'hF3, 8'hF4);
    run_all();
    chk("t6_ndv", n_dv, 8);
    chk("t6_nfs", n_fs, 2);
    chk("t6_nfe", n_fe, 2);

    // 256 frames: counter wraps
    nb = 0;
    for (int f = 0; f < 256; f++) begin
      r0 = 8'($urandom); r1 = 8'($urandom); r2 = 8'($urandom); r3 = 8'($urandom);
      push_frame(r0, r1, r2, r3);
    end
    run_all();
    chk("t3_nfe", n_fe, 256);
    chk("t3_nfs", n_fs, 256);
    chk("t3_ndv", n_dv, 1024);
    chk("t3_fcnt", frame_cnt, 0);

    // Asynchronous reset after two payload bytes
    nb = 0;
    push_frame(8'h12, 8'h34, 8'h56, 8'h78);
    build_model();
    do_reset();
    run_bits(8 + 2 * NB + 3);
    chk("t4_ndv_pre", n_dv, 2);
    chk("t4_locked_pre", locked, 1);
    #3;
    rst = 0;
    #1;
    chk_zero("t4_async");
    nb = 0;
    push_frame(8'h11, 8'h22, 8'h33, 8'h44);
    run_all();
    chk("t4_fcnt", frame_cnt, 1);
    chk("t4_ndv", n_dv, 4);
    chk("t4_b0", got[0], 8'h11);

`ifdef BIT_FRAMER_PARITY_EN
    // Wrong parity on the first byte, then a clean frame
    nb = 0;
    push_raw(SYNC);
    push_byte(8'h12, 1'b1);
    push_frame(8'h12, 8'h34, 8'h56, 8'h78);
    run_all();
    chk("t5_npe", n_pe, 1);
    chk("t5_nfs", n_fs, 2);
    chk("t5_ndv", n_dv, 4);
    chk("t5_b0", got[0], 8'h12);
    chk("t5_fcnt", frame_cnt, 1);
`endif

    // Random noise interleaved with random frames
    nb = 0;
    for (int f = 0; f < 20; f++) begin
      for (int i = 0; i < int'($urandom_range(0, 20)); i++) push_bit(1'($urandom));
      push_raw(SYNC);
      for (int b = 0; b < LEN; b++) begin
        r0 = 8'($urandom);
        push_byte(r0, ($urandom_range(0, 5) == 0));
      end
    end
    run_all();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
